instr_mem_sync: RTL and testbench
=================================

Name: instr_mem_sync

Overview:
Parametrised, synchronous instruction memory for the MIPS32 fetch stage. It replaces the hard-coded combinational instruction ROM with a clocked, writable RAM. The RAM has a request/valid read handshake, a configurable read latency of 1 or 2 cycles, and a program-load port so a boot loader or bench can write code. Faulting fetches (misaligned or out of range) are flagged and return a NOP instead of X.

Parameters:
DATA_WIDTH, 32, instruction width in bits
ADDR_WIDTH, 32, byte-address width of fetch and program ports
DEPTH, 256, number of instruction words; power of two, 4..65536
READ_LATENCY, 1, cycles from accepted request to InstrValid; legal values 1 or 2
INIT_FILE, "", hex image loaded with $readmemh at elaboration; empty means contents undefined
NOP_WORD, 32'h00000000, word returned on a faulting fetch (sll $0,$0,0)

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
ReqValid  in  1  fetch request valid
Address  in  ADDR_WIDTH  fetch byte address (PC)
Stall  in  1  freeze read pipeline and hold outputs
Instruction  out  DATA_WIDTH  fetched word
InstrValid  out  1  Instruction/Fault valid this cycle
Fault  out  2  bit0 misaligned, bit1 out of range; qualified by InstrValid
ProgWe  in  1  program-port write enable
ProgAddr  in  ADDR_WIDTH  program byte address
ProgData  in  DATA_WIDTH  program write data
ProgErr  out  1  one-cycle pulse: previous-cycle write was dropped

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - Instruction=NOP_WORD, InstrValid=0, Fault=0, ProgErr=0.
  - All pipeline stages are cleared and in-flight fetches are dropped.
  - RAM contents are not reset.
  - ProgWe is ignored while Rst_n=0.
- Address decode:
  - Word index = Address[log2(DEPTH)+1:2].
  - Misaligned when Address[1:0]!=0.
  - Out of range when any Address bit above log2(DEPTH)+1 is set.
  - When both conditions hold, both Fault bits are set.
- Read acceptance: a request is accepted on a rising edge where ReqValid=1 and Stall=0.
- Read response:
  - READ_LATENCY=1: response on the next edge.
  - READ_LATENCY=2: one extra register stage.
  - Fully pipelined; back-to-back requests give one response per cycle.
- Response content:
  - Non-faulting request: Instruction=RAM[index], Fault=0, InstrValid=1 for exactly one cycle, unless stalled.
  - Faulting request: Instruction=NOP_WORD, Fault as decoded, InstrValid=1. The RAM is not read.
- No request: a cycle with no accepted request produces InstrValid=0 in the corresponding output cycle. Instruction keeps its last value and is not cleared.
- Stall=1:
  - All read-pipeline registers hold, including InstrValid, Instruction and Fault, so a valid response stays asserted until Stall falls.
  - ReqValid is ignored; the requester must hold Address.
  - Stall has no effect on the program port.
- Program port writes:
  - On an edge with ProgWe=1, ProgAddr aligned and in range, RAM[ProgAddr index] is written with ProgData.
  - A misaligned or out-of-range write is dropped, and ProgErr pulses high for one cycle on the following cycle.
- Read/write collision: when a read and a write hit the same word on the same edge, the read returns the new ProgData (write-first bypass). A write to a different word does not disturb the read.
- Implementation constraints:
  - Storage must infer block RAM; no reset on the storage array.
  - Width of DATA_WIDTH != 32 is legal; NOP_WORD is truncated or zero-extended to DATA_WIDTH.

Test Plan:
- Load and read back:
  - Program 0x8e680021 @0x00, 0x8e680020 @0x04, 0x22720004 @0x08.
  - Issue requests to 0x00, 0x04, 0x08 on consecutive cycles with READ_LATENCY=1.
  - Required: InstrValid=1 for 3 consecutive cycles starting 1 cycle after the first request, with the same words in order and Fault=0.
- Fetch faults (DEPTH=256):
  - Address 0x06 -> Instruction=0x00000000, Fault=2'b01.
  - Address 0x400 -> Fault=2'b10.
  - Address 0x402 -> Fault=2'b11.
  - No RAM contents change.
- Stall hold and latency (READ_LATENCY=2):
  - Request 0x04, then assert Stall for 3 cycles starting when InstrValid rises.
  - Required: Instruction=0x8e680020 and InstrValid=1 held for all 3 cycles; a ReqValid pulse during Stall produces no extra response.
- Collision: write 0xDEADBEEF @0x08 on the same edge a read of 0x08 is accepted -> response is 0xDEADBEEF; a subsequent read of 0x08 is also 0xDEADBEEF.
- Bad writes: ProgWe to 0x0A and to 0x1000 -> ProgErr pulses one cycle after each write; reading 0x08 and 0x00 afterwards shows the old contents.
- Reset mid-operation:
  - Deassert Rst_n asynchronously (not on a clock edge) with 2 requests in flight (READ_LATENCY=2).
  - Required: InstrValid=0 immediately; Instruction=0x00000000; no stale response after Rst_n rises; RAM contents survive (0x00 still reads 0x8e680021).

Source files
------------

// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - synchronous, writable MIPS32 instruction memory with pipelined fetch
//
// Purpose: clocked instruction RAM for the fetch stage. A fetch request is
// accepted on a rising edge with ReqValid=1 and Stall=0. The response appears
// READ_LATENCY (1 or 2) edges later with InstrValid=1. Misaligned or
// out-of-range fetches return NOP_WORD and report the cause on Fault. The
// program port writes the RAM. A dropped write raises ProgErr for one cycle.
//
// Ports:
//   Clk, Rst_n         clock (rising edge), asynchronous active-low reset
//   ReqValid, Address  fetch request and byte address (PC)
//   Stall              freezes the read pipeline and holds the outputs
//   Instruction        fetched word (holds its last value when no response)
//   InstrValid         Instruction/Fault valid this cycle
//   Fault              bit0 misaligned, bit1 out of range
//   ProgWe, ProgAddr, ProgData  program-port write
//   ProgErr            one-cycle pulse: previous-cycle write was dropped

module instr_mem_sync #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DEPTH        = 256,
    parameter int          READ_LATENCY = 1,
    parameter string       INIT_FILE    = "",
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  ReqValid,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  Stall,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  InstrValid,
    output logic [1:0]            Fault,
    input  logic                  ProgWe,
    input  logic [ADDR_WIDTH-1:0] ProgAddr,
    input  logic [DATA_WIDTH-1:0] ProgData,
    output logic                  ProgErr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_WORD);

    // Address decode for both ports
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_mis;
    logic             rd_oor;
    logic             wr_mis;
    logic             wr_oor;
    logic [1:0]       rd_fault;
    logic             rd_faulty;
    logic             wr_ok;
    logic             accept;
    logic             collide;

    assign rd_idx    = Address[IDX_W+1:2];
    assign wr_idx    = ProgAddr[IDX_W+1:2];
    assign rd_mis    = |Address[1:0];
    assign wr_mis    = |ProgAddr[1:0];
    // Any bit above the word index makes the address out of range.
    assign rd_oor    = (Address >> (IDX_W + 2)) != '0;
    assign wr_oor    = (ProgAddr >> (IDX_W + 2)) != '0;
    assign rd_fault  = {rd_oor, rd_mis};
    assign rd_faulty = |rd_fault;
    assign wr_ok     = ProgWe && !wr_mis && !wr_oor;
    assign accept    = ReqValid && !Stall;
    assign collide   = wr_ok && (wr_idx == rd_idx);

    // Storage: no reset so it maps onto block RAM
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Writes are gated by Rst_n so the program port is inert during reset.
    always_ff @(posedge Clk) begin
        if (Rst_n && wr_ok) begin
            mem_q[wr_idx] <= ProgData;
        end
    end

    // Stage 1 data: the RAM read register, plus a side register holding the
    // write data for a same-word collision. Keeping the bypass outside the RAM
    // read path leaves the read register as a plain synchronous RAM output.
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] byp_data_q;

    always_ff @(posedge Clk) begin
        if (accept && !rd_faulty) begin
            rd_data_q <= mem_q[rd_idx];
        end
        if (accept && !rd_faulty && collide) begin
            byp_data_q <= ProgData;
        end
    end

    // Stage 1 control
    logic       s1_valid_q, s1_valid_d;
    logic [1:0] s1_fault_q, s1_fault_d;
    logic       s1_nop_q,   s1_nop_d;
    logic       s1_byp_q,   s1_byp_d;
    logic       prog_err_q, prog_err_d;

    // The data-select flags change only on an accepted request, so Instruction
    // keeps its last value across idle cycles.
    always_comb begin
        s1_valid_d = ReqValid;
        s1_fault_d = ReqValid ? rd_fault : 2'b00;
        s1_nop_d   = s1_nop_q;
        s1_byp_d   = s1_byp_q;
        if (ReqValid) begin
            s1_nop_d = rd_faulty;
            s1_byp_d = collide && !rd_faulty;
        end
        prog_err_d = ProgWe && !wr_ok;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid_q <= 1'b0;
            s1_fault_q <= 2'b00;
            s1_nop_q   <= 1'b1;
            s1_byp_q   <= 1'b0;
            prog_err_q <= 1'b0;
        end else begin
            prog_err_q <= prog_err_d;
            if (!Stall) begin
                s1_valid_q <= s1_valid_d;
                s1_fault_q <= s1_fault_d;
                s1_nop_q   <= s1_nop_d;
                s1_byp_q   <= s1_byp_d;
            end
        end
    end

    logic [DATA_WIDTH-1:0] s1_instr;
    assign s1_instr = s1_nop_q ? NOP : (s1_byp_q ? byp_data_q : rd_data_q);

    assign ProgErr = prog_err_q;

    // Optional second register stage
    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid_q;
        logic [1:0]            s2_fault_q;
        logic [DATA_WIDTH-1:0] s2_instr_q;

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                s2_valid_q <= 1'b0;
                s2_fault_q <= 2'b00;
                s2_instr_q <= NOP;
            end else if (!Stall) begin
                s2_valid_q <= s1_valid_q;
                s2_fault_q <= s1_fault_q;
                if (s1_valid_q) begin
                    s2_instr_q <= s1_instr;
                end
            end
        end

        assign Instruction = s2_instr_q;
        assign InstrValid  = s2_valid_q;
        assign Fault       = s2_fault_q;
    end else begin : g_lat1
        assign Instruction = s1_instr;
        assign InstrValid  = s1_valid_q;
        assign Fault       = s1_fault_q;
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb/tb_instr_mem_sync.sv - scoreboard bench for instr_mem_sync at read latency 1 and 2

module tb_instr_mem_sync;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        ReqValid;
    logic        Stall;
    logic [31:0] Address;
    logic        ProgWe;
    logic [31:0] ProgAddr;
    logic [31:0] ProgData;

    logic [31:0] instr1, instr2;
    logic        v1, v2;
    logic [1:0]  f1, f2;
    logic        pe1, pe2;

    always #5 Clk = ~Clk;

    instr_mem_sync #(.DEPTH(256), .READ_LATENCY(1)) u_lat1 (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .Address(Address), .Stall(Stall),
        .Instruction(instr1), .InstrValid(v1), .Fault(f1),
        .ProgWe(ProgWe), .ProgAddr(ProgAddr), .ProgData(ProgData), .ProgErr(pe1)
    );

    instr_mem_sync #(.DEPTH(256), .READ_LATENCY(2)) u_lat2 (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .Address(Address), .Stall(Stall),
        .Instruction(instr2), .InstrValid(v2), .Fault(f2),
        .ProgWe(ProgWe), .ProgAddr(ProgAddr), .ProgData(ProgData), .ProgErr(pe2)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  fault;
        int          due;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] model_mem [256];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    // Compare one DUT's output against its expectation queue after an edge.
    task automatic score(input string name, input int which, input logic v,
                         input logic [31:0] ins, input logic [1:0] f, input logic held);
        exp_t e;
        int   depth;
        depth = (which == 1) ? q1.size() : q2.size();
        if (held) return;
        if (v) begin
            vectors++;
            if (depth == 0) begin
                miscompares++;
                $display("FAIL %s_extra_response: got valid instr=%h fault=%b at cycle %0d, required no response",
                         name, ins, f, cyc);
            end else begin
                e = (which == 1) ? q1.pop_front() : q2.pop_front();
                if (ins !== e.data || f !== e.fault || cyc !== e.due) begin
                    miscompares++;
                    $display("FAIL %s_response: got instr=%h fault=%b cycle=%0d, required instr=%h fault=%b cycle=%0d",
                             name, ins, f, cyc, e.data, e.fault, e.due);
                end
            end
        end else if (depth > 0) begin
            e = (which == 1) ? q1[0] : q2[0];
            if (e.due <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_missing_response: got InstrValid=0 at cycle %0d, required instr=%h",
                         name, cyc, e.data);
                if (which == 1) void'(q1.pop_front());
                else void'(q2.pop_front());
            end
        end
    endtask

    // Advance one clock: model the edge, then check both DUTs on the falling edge.
    task automatic step();
        exp_t       e;
        logic [7:0] ri, wi;
        logic       wok, held, perr_exp;
        @(posedge Clk);
        cyc++;
        held = Stall;
        wi   = ProgAddr[9:2];
        wok  = ProgWe && (ProgAddr[1:0] == 2'b00) && (ProgAddr < 32'h400);
        if (Rst_n && ReqValid && !Stall) begin
            ri      = Address[9:2];
            e.fault = {Address >= 32'h400, Address[1:0] != 2'b00};
            e.due   = cyc;
            if (e.fault != 2'b00) e.data = 32'h0000_0000;
            else if (wok && wi == ri) e.data = ProgData;
            else e.data = model_mem[ri];
            q1.push_back(e);
            e.due = cyc + 1;
            q2.push_back(e);
        end
        perr_exp = Rst_n && ProgWe && !wok;
        if (Rst_n && wok) model_mem[wi] = ProgData;
        @(negedge Clk);
        score("lat1", 1, v1, instr1, f1, held);
        score("lat2", 2, v2, instr2, f2, held);
        vectors++;
        if (pe1 !== perr_exp || pe2 !== perr_exp) begin
            miscompares++;
            $display("FAIL prog_err: got %b/%b, required %b at cycle %0d", pe1, pe2, perr_exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        ReqValid = 1'b0;
        ProgWe   = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        ProgWe = 1'b1; ProgAddr = a; ProgData = d;
        step();
        ProgWe = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b1; ReqValid = 1'b0; Stall = 1'b0; Address = '0;
        ProgWe = 1'b0; ProgAddr = '0; ProgData = '0;
        #2 Rst_n = 1'b0;
        #1;
        vectors++;
        if (instr1 !== 32'h0 || instr2 !== 32'h0 || v1 !== 1'b0 || v2 !== 1'b0 ||
            f1 !== 2'b00 || f2 !== 2'b00 || pe1 !== 1'b0 || pe2 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got instr=%h/%h valid=%b/%b fault=%b/%b err=%b/%b, required all zero",
                     instr1, instr2, v1, v2, f1, f2, pe1, pe2);
        end
        idle(2);
        Rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_load_readback();
        write(32'h00, 32'h8e680021);
        write(32'h04, 32'h8e680020);
        write(32'h08, 32'h22720004);
        write(32'h10, 32'h11111111);
        ReqValid = 1'b1;
        Address = 32'h00; step();
        Address = 32'h04; step();
        Address = 32'h08; step();
        idle(3);
    endtask

    task automatic test_fetch_faults();
        ReqValid = 1'b1;
        Address = 32'h006; step();
        Address = 32'h400; step();
        Address = 32'h402; step();
        Address = 32'h000; step();
        Address = 32'h004; step();
        idle(3);
    endtask

    task automatic test_stall_hold();
        ReqValid = 1'b1; Address = 32'h04;
        step();
        ReqValid = 1'b0;
        step();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ReqValid = (i == 1);
            Address  = 32'h08;
            step();
            vectors++;
            if (v2 !== 1'b1 || instr2 !== 32'h8e680020 || f2 !== 2'b00) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got valid=%b instr=%h fault=%b, required 1 8e680020 00",
                         i, v2, instr2, f2);
            end
        end
        Stall = 1'b0; ReqValid = 1'b0;
        step();
        vectors++;
        if (v2 !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: got valid=%b, required 0", v2);
        end
        idle(3);
    endtask

    task automatic test_collision();
        ReqValid = 1'b1; Address = 32'h08;
        ProgWe = 1'b1; ProgAddr = 32'h08; ProgData = 32'hDEADBEEF;
        step();
        ProgWe = 1'b0;
        step();
        idle(3);
    endtask

    task automatic test_bad_writes();
        ProgWe = 1'b1; ProgAddr = 32'h0A; ProgData = 32'h55555555;
        step();
        vectors++;
        if (pe1 !== 1'b1 || pe2 !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_write_misaligned: got ProgErr=%b/%b, required 1", pe1, pe2);
        end
        ProgAddr = 32'h1000; ProgData = 32'h66666666;
        step();
        vectors++;
        if (pe1 !== 1'b1 || pe2 !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_write_range: got ProgErr=%b/%b, required 1", pe1, pe2);
        end
        ProgWe = 1'b0;
        ReqValid = 1'b1; Address = 32'h08;
        step();
        vectors++;
        if (pe1 !== 1'b0 || pe2 !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_write_pulse_end: got ProgErr=%b/%b, required 0", pe1, pe2);
        end
        Address = 32'h00;
        step();
        idle(3);
    endtask

    task automatic test_reset_mid();
        ReqValid = 1'b1; Address = 32'h00;
        step();
        Address = 32'h04;
        @(posedge Clk);
        cyc++;
        #3 Rst_n = 1'b0;
        #1;
        q1.delete();
        q2.delete();
        vectors++;
        if (v1 !== 1'b0 || v2 !== 1'b0 || instr1 !== 32'h0 || instr2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got valid=%b/%b instr=%h/%h, required 0 and 00000000",
                     v1, v2, instr1, instr2);
        end
        ReqValid = 1'b0;
        @(negedge Clk);
        ProgWe = 1'b1; ProgAddr = 32'h10; ProgData = 32'h22222222;
        step();
        step();
        ProgWe = 1'b0;
        #2 Rst_n = 1'b1;
        idle(4);
        ReqValid = 1'b1;
        Address = 32'h00; step();
        Address = 32'h10; step();
        idle(3);
    endtask

    initial begin
        test_reset();
        test_load_readback();
        test_fetch_faults();
        test_stall_hold();
        test_collision();
        test_bad_writes();
        test_reset_mid();
        vectors++;
        if (q1.size() != 0 || q2.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d responses outstanding, required 0", q1.size(), q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
